ser_par_align: RTL and testbench



---
 rtl/ser_par_align_pkg.sv | 21 ++
 rtl/ser_par_align.sv | 108 ++++++++++
 tb/tb_ser_par_align.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ser_par_align_pkg.sv
// Shared constants and state encoding for the receive-side serial-to-parallel aligner.
package ser_par_align_pkg;

  // Alignment/idle symbol the transmitter sends whenever it has no valid data.
  localparam logic [7:0] ComSymDefault = 8'hBC;

  // clk_32f runs at this multiple of clk_4f; one byte spans this many bit clocks.
  localparam int unsigned BitRatio = 8;
  localparam int unsigned BitCntW  = $clog2(BitRatio);

  // Width of the consecutive-COM counter; wide enough for lock counts up to 15.
  localparam int unsigned ComCntW = 4;

  // Encoding 2'd3 is illegal and recovers to StSearch.
  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StAlign  = 2'd1,
    StLocked = 2'd2
  } state_e;

endpackage

// File: rtl/ser_par_align.sv
// Serial-to-parallel converter with COM-based byte alignment and lock detection.
module ser_par_align
  import ser_par_align_pkg::*;
#(
  parameter logic [7:0]  COM_SYM    = ComSymDefault,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_sp,
  output logic       valid_sp,
  output logic       active
);

  localparam logic [BitCntW-1:0] BitCntLast  = BitCntW'(BitRatio - 1);
  // Boundary COM count at which the run is long enough to lock.
  localparam logic [ComCntW-1:0] ComCntLast  = ComCntW'(LOCK_COUNT - 1);
  localparam bit                 LockOnFirst = (LOCK_COUNT == 1);

  logic [6:0]         sr_q, sr_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [ComCntW-1:0] com_cnt_q, com_cnt_d;
  state_e             state_q, state_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;

  logic [7:0] window;
  logic       win_is_com;
  logic       boundary;

  assign window     = {sr_q, data_in};
  assign win_is_com = (window == COM_SYM);
  assign boundary   = (bit_cnt_q == BitCntLast);

  // Next-state: shift in the new bit, track byte phase, and run the alignment FSM.
  always_comb begin
    sr_d      = window[6:0];
    bit_cnt_d = bit_cnt_q + BitCntW'(1);
    com_cnt_d = com_cnt_q;
    state_d   = state_q;
    data_d    = data_q;
    valid_d   = valid_q;

    case (state_q)
      StSearch: begin
        // First COM seen in the bit stream fixes the byte phase.
        if (win_is_com) begin
          bit_cnt_d = '0;
          com_cnt_d = ComCntW'(1);
          state_d   = LockOnFirst ? StLocked : StAlign;
        end
      end
      StAlign: begin
        if (boundary) begin
          if (win_is_com) begin
            com_cnt_d = com_cnt_q + ComCntW'(1);
            if (com_cnt_q == ComCntLast) begin
              state_d = StLocked;
            end
          end else begin
            com_cnt_d = '0;
            state_d   = StSearch;
          end
        end
      end
      StLocked: begin
        // COM bytes are idle fill and never reach the reassembly stage.
        if (boundary) begin
          if (win_is_com) begin
            data_d  = 8'h00;
            valid_d = 1'b0;
          end else begin
            data_d  = window;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StSearch;
      end
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      state_q   <= StSearch;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  assign data_sp  = data_q;
  assign valid_sp = valid_q;
  assign active   = (state_q == StLocked);

endmodule

// File: tb/tb_ser_par_align.sv
// Scoreboard bench: two DUTs (lock count 4 and 1) share one serial stimulus stream.
module tb_ser_par_align;

  localparam logic [7:0] Com = 8'hBC;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic       a;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       data_in;
  logic [7:0] data_sp0, data_sp1;
  logic       valid_sp0, valid_sp1;
  logic       active0, active1;

  int vectors;
  int miscompares;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  // Reference model state: bit history since reset plus per-instance alignment view.
  bit         hist[$];
  int         mode    [2];  // 0 searching, 1 counting COMs, 2 locked
  int         run     [2];
  int         match_n [2];
  logic [7:0] od      [2];
  logic       ov      [2];

  ser_par_align #(.LOCK_COUNT(4)) u_dut0 (
    .clk_32f (clk),
    .reset   (reset),
    .data_in (data_in),
    .data_sp (data_sp0),
    .valid_sp(valid_sp0),
    .active  (active0)
  );

  ser_par_align #(.LOCK_COUNT(1)) u_dut1 (
    .clk_32f (clk),
    .reset   (reset),
    .data_in (data_in),
    .data_sp (data_sp1),
    .valid_sp(valid_sp1),
    .active  (active1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lock_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // Byte boundaries fall every 8 bits after the bit index of the aligning COM.
  task automatic model_step(input logic r, input logic b);
    exp_t       e;
    logic [7:0] win;
    int         n;
    int         idx;
    bit         bnd;
    if (r) begin
      hist.delete();
      for (int k = 0; k < 2; k++) begin
        mode[k] = 0; run[k] = 0; match_n[k] = 0; od[k] = 8'h00; ov[k] = 1'b0;
      end
    end else begin
      hist.push_back(b);
      n = hist.size() - 1;
      win = 8'h00;
      for (int i = 0; i < 8; i++) begin
        idx = n - 7 + i;
        win[7-i] = (idx >= 0) ? hist[idx] : 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
        bnd = (n > match_n[k]) && (((n - match_n[k]) % 8) == 0);
        if (mode[k] == 0) begin
          if (win == Com) begin
            match_n[k] = n;
            run[k] = 1;
            mode[k] = (lock_of(k) == 1) ? 2 : 1;
          end
        end else if (mode[k] == 1) begin
          if (bnd) begin
            if (win == Com) begin
              run[k]++;
              if (run[k] == lock_of(k)) mode[k] = 2;
            end else begin
              mode[k] = 0;
            end
          end
        end else if (bnd) begin
          od[k] = (win == Com) ? 8'h00 : win;
          ov[k] = (win != Com);
        end
      end
    end
    e.d = od[0]; e.v = ov[0]; e.a = (mode[0] == 2);
    exp_q0.push_back(e);
    e.d = od[1]; e.v = ov[1]; e.a = (mode[1] == 2);
    exp_q1.push_back(e);
  endtask

  task automatic send_bit(input logic r, input logic b);
    @(posedge clk);
    #2;
    reset   = r;
    data_in = b;
    model_step(r, b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(1'b0, v[i]);
  endtask

  task automatic send_reset(input int cycles);
    for (int i = 0; i < cycles; i++) send_bit(1'b1, 1'b0);
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  // Monitor: one expected record per clock edge, compared 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        check("lc4 data_sp", data_sp0, e.d);
        check("lc4 valid_sp", {7'd0, valid_sp0}, {7'd0, e.v});
        check("lc4 active", {7'd0, active0}, {7'd0, e.a});
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        check("lc1 data_sp", data_sp1, e.d);
        check("lc1 valid_sp", {7'd0, valid_sp1}, {7'd0, e.v});
        check("lc1 active", {7'd0, active1}, {7'd0, e.a});
      end
    end
  end

  initial begin
    int         sel;
    int         nbits;
    logic [7:0] rb;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    data_in     = 1'b0;

    // Basic lock then three data bytes.
    send_reset(2);
    repeat (4) send_byte(Com);
    send_byte(8'hFF); send_byte(8'h00); send_byte(8'hA5);
    repeat (2) send_byte(Com);

    // Leading garbage offsets the byte phase.
    send_reset(1);
    send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b1);
    repeat (4) send_byte(Com);
    send_byte(8'h12); send_byte(Com);

    // Broken COM run drops back to search, then relocks.
    send_reset(1);
    repeat (3) send_byte(Com);
    send_byte(8'h55);
    repeat (4) send_byte(Com);
    send_byte(8'h34);

    // Locked stream with an interleaved COM.
    send_byte(8'h11); send_byte(Com); send_byte(8'h22);

    // Reset mid-byte while locked, then too-short and full COM runs.
    for (int i = 0; i < 4; i++) send_bit(1'b0, i[0]);
    send_reset(1);
    repeat (3) send_byte(Com);
    send_byte(8'h77);
    repeat (4) send_byte(Com);
    send_byte(8'h66);

    // Single COM then data: only the lock-count-1 instance emits 0x9A.
    send_reset(1);
    send_byte(Com); send_byte(8'h9A); send_byte(Com);

    // Randomized traffic mixing COM runs, data, phase slips and resets.
    for (int it = 0; it < 400; it++) begin
      sel = $urandom_range(0, 99);
      if (sel < 2) begin
        send_reset($urandom_range(1, 3));
      end else if (sel < 8) begin
        nbits = $urandom_range(1, 7);
        for (int j = 0; j < nbits; j++) send_bit(1'b0, 1'($urandom_range(0, 1)));
      end else if (sel < 55) begin
        send_byte(Com);
      end else begin
        rb = 8'($urandom_range(0, 255));
        send_byte(rb);
      end
    end

    repeat (3) @(posedge clk);
    #3;
    vectors++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: got %0d/%0d pending expected 0",
               exp_q0.size(), exp_q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
